// File: rtl/lpo_monitor_pkg.sv
// Shared definitions for the lower-part-OR adder error monitor.
// Contents: default parameter values, the window FSM state type and
// an absolute-difference helper used by the error pipeline.
package lpo_monitor_pkg;

  localparam int LPO_WIDTH       = 32;
  localparam int LPO_LOWER_WIDTH = 8;
  localparam int LPO_CNT_W       = 16;
  localparam int LPO_ACC_W       = 48;

  // Operand width of abs_diff; callers zero-extend into it and truncate
  // the result back to their own width (valid for WIDTH+1 <= ABS_W).
  localparam int ABS_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lpo_state_e;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    logic [ABS_W-1:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

endpackage

// File: rtl/lpo_error_pipe.sv
// Two-stage error pipeline: S1 registers the exact sum and the adder's
// approximate sum, S2 registers their absolute difference.
// Ports: clk_i/rst_ni, in_valid_i + operands/approx in, dist_o with
// dist_valid_o out, empty_o when neither stage holds a sample.
module lpo_error_pipe
  import lpo_monitor_pkg::*;
#(
  parameter int WIDTH = LPO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   approx_i,
  output logic [WIDTH:0]   dist_o,
  output logic             dist_valid_o,
  output logic             empty_o
);

  logic [WIDTH:0] exact_q, exact_d;
  logic [WIDTH:0] approx_q;
  logic [WIDTH:0] dist_q, dist_d;
  logic           v1_q, v2_q;

  // Exact sum of the incoming operands and distance of the S1 sample.
  always_comb begin
    exact_d = {1'b0, add1_i} + {1'b0, add2_i};
    dist_d  = (WIDTH+1)'(abs_diff(ABS_W'(exact_q), ABS_W'(approx_q)));
  end

  // Pipeline registers; the pipe never stalls, bubbles flow as invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
      dist_q   <= '0;
    end else begin
      v1_q     <= in_valid_i;
      v2_q     <= v1_q;
      exact_q  <= exact_d;
      approx_q <= approx_i;
      dist_q   <= dist_d;
    end
  end

  assign dist_o       = dist_q;
  assign dist_valid_o = v2_q;
  assign empty_o      = !v1_q && !v2_q;

endmodule

// File: rtl/lpo_monitor_checker.sv
// Observation-only checker for the error monitor: on every accepted
// sample the approximate sum's lower part must equal the OR of the
// operand lower parts. Violations are reported as warnings only.
// Ports: clk_i, rst_ni, hs_i (handshake), lower operand/result slices.
module lpo_monitor_checker #(
  parameter int LOWER_WIDTH = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic                   hs_i,
  input logic [LOWER_WIDTH-1:0] add1_lo_i,
  input logic [LOWER_WIDTH-1:0] add2_lo_i,
  input logic [LOWER_WIDTH-1:0] approx_lo_i
);

  a_lower_part_or : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    hs_i |-> (approx_lo_i == (add1_lo_i | add2_lo_i))
  ) else $warning("approx lower part is not add1|add2");

endmodule

// File: rtl/lower_part_or_error_monitor32.sv
// Error-statistics monitor for the 32-bit lower-part-OR approximate adder.
// A window of num_samples_i samples is accepted after start_i; for each
// one the |exact - approx| distance is accumulated into an error count,
// a saturating distance sum and a running maximum.
// Ports: clk_i/rst_ni; start_i/num_samples_i control; valid_i/ready_o
// sample handshake with add1_i/add2_i/approx_i; busy_o, done_o pulse,
// err_count_o, err_sum_o, err_max_o statistics (held until next start).
module lower_part_or_error_monitor32
  import lpo_monitor_pkg::*;
#(
  parameter int WIDTH       = LPO_WIDTH,
  parameter int LOWER_WIDTH = LPO_LOWER_WIDTH,
  parameter int CNT_W       = LPO_CNT_W,
  parameter int ACC_W       = LPO_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   approx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [ACC_W-1:0] err_sum_o,
  output logic [WIDTH:0]   err_max_o
);

  // Sum width wide enough that one addition cannot wrap before the
  // saturation test, whichever of ACC_W and WIDTH+1 is larger.
  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  lpo_state_e     state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [WIDTH:0]   max_q, max_d;
  logic [SUM_W-1:0] sum_ext_s;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             hs_s, clr_s;
  logic [WIDTH:0]   dist_s;
  logic             dist_valid_s, pipe_empty_s;

  assign hs_s = valid_i && ready_q;

  lpo_error_pipe #(.WIDTH(WIDTH)) u_pipe (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (hs_s),
    .add1_i       (add1_i),
    .add2_i       (add2_i),
    .approx_i     (approx_i),
    .dist_o       (dist_s),
    .dist_valid_o (dist_valid_s),
    .empty_o      (pipe_empty_s)
  );

  lpo_monitor_checker #(.LOWER_WIDTH(LOWER_WIDTH)) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hs_i        (hs_s),
    .add1_lo_i   (add1_i[LOWER_WIDTH-1:0]),
    .add2_lo_i   (add2_i[LOWER_WIDTH-1:0]),
    .approx_lo_i (approx_i[LOWER_WIDTH-1:0])
  );

  // Window FSM next state, window length latch and accepted counter.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    acc_d   = acc_q;
    clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_d   = num_samples_i;
          acc_d   = CNT_W'(0);
          clr_s   = 1'b1;
          state_d = (num_samples_i != CNT_W'(0)) ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          acc_d   = acc_q + CNT_W'(1);
          state_d = (acc_d == num_q) ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they can be registered.
  always_comb begin
    ready_d = (state_d == ST_RUN) && (acc_d < num_d);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // Statistics update from the S2 distance; cleared on accepted start.
  always_comb begin
    sum_ext_s = SUM_W'(sum_q) + SUM_W'(dist_s);
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    max_d     = max_q;
    if (clr_s) begin
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (dist_valid_s) begin
      cnt_d = cnt_q + CNT_W'(dist_s != '0);
      if (|sum_ext_s[SUM_W-1:ACC_W]) begin
        sum_d = '1;
      end else begin
        sum_d = sum_ext_s[ACC_W-1:0];
      end
      max_d = (dist_s > max_q) ? dist_s : max_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, control and statistics registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_count_o = cnt_q;
  assign err_sum_o   = sum_q;
  assign err_max_o   = max_q;

endmodule

// File: tb/tb_lower_part_or_error_monitor32.sv
// Directed self-checking bench for lower_part_or_error_monitor32. A second
// instance with an 8-bit accumulator shares the stimulus to exercise
// saturation of the error sum.
`timescale 1ns/1ps
module tb_lower_part_or_error_monitor32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num = 16'd0;
  logic        valid = 1'b0;
  logic [31:0] a1 = 32'd0;
  logic [31:0] a2 = 32'd0;
  logic [32:0] apx = 33'd0;

  logic        ready, busy, done;
  logic [15:0] cnt;
  logic [47:0] sum;
  logic [32:0] mx;
  logic        s_ready, s_busy, s_done;
  logic [15:0] s_cnt;
  logic [7:0]  s_sum;
  logic [32:0] s_mx;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int ready_cnt = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  lower_part_or_error_monitor32 u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_samples_i(num),
    .valid_i(valid), .ready_o(ready), .add1_i(a1), .add2_i(a2),
    .approx_i(apx), .busy_o(busy), .done_o(done), .err_count_o(cnt),
    .err_sum_o(sum), .err_max_o(mx)
  );

  lower_part_or_error_monitor32 #(.ACC_W(8)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_samples_i(num),
    .valid_i(valid), .ready_o(s_ready), .add1_i(a1), .add2_i(a2),
    .approx_i(apx), .busy_o(s_busy), .done_o(s_done), .err_count_o(s_cnt),
    .err_sum_o(s_sum), .err_max_o(s_mx)
  );

  // Event counters, sampled mid-cycle when all DUT outputs are stable.
  always @(negedge clk) begin
    if (done)          done_cnt++;
    if (ready)         ready_cnt++;
    if (valid && ready) hs_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num   = n;
    cycle();
    start = 1'b0;
  endtask

  // Present a sample until it is accepted; optionally keep valid high.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic [32:0] z, input bit hold);
    int w;
    valid = 1'b1;
    a1 = x; a2 = y; apx = z;
    w = 0;
    while (!ready && w < 20) begin
      cycle();
      w++;
    end
    if (w >= 20) check("ready_timeout", {63'd0, ready}, 64'd1);
    cycle();
    if (!hold) valid = 1'b0;
  endtask

  // Wait (bounded) for done_o; on return the statistics are final.
  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, {63'd0, got}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) cycle();
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_cnt",   64'(cnt), 64'd0);
    check("rst_sum",   64'(sum), 64'd0);
    check("rst_max",   64'(mx),  64'd0);
    rst_n = 1'b1;
    cycle();

    // Single sample: exact 0x100, approx 0x0FF -> distance 1.
    do_start(16'd1);
    check("t1_busy", {63'd0, busy}, 64'd1);
    send(32'h0000_00FF, 32'h0000_0001, 33'h0_0000_00FF, 1'b0);
    wait_done("t1");
    check("t1_cnt", 64'(cnt), 64'd1);
    check("t1_sum", 64'(sum), 64'd1);
    check("t1_max", 64'(mx),  64'd1);
    cycle();
    check("t1_done_pulse", {63'd0, done}, 64'd0);
    check("t1_idle_busy",  {63'd0, busy}, 64'd0);
    check("t1_hold_cnt",   64'(cnt), 64'd1);

    // Two samples: distance 0x80 then 0.
    do_start(16'd2);
    check("t2_clr_cnt", 64'(cnt), 64'd0);
    send(32'h0000_0080, 32'h0000_0080, 33'h0_0000_0180, 1'b0);
    send(32'h0000_0010, 32'h0000_0020, 33'h0_0000_0030, 1'b0);
    wait_done("t2");
    check("t2_cnt", 64'(cnt), 64'd1);
    check("t2_sum", 64'(sum), 64'h80);
    check("t2_max", 64'(mx),  64'h80);
    cycle();

    // Empty window: DONE right after the start edge, nothing accepted.
    ready_cnt = 0;
    d0 = done_cnt;
    do_start(16'd0);
    check("t3_done_now", {63'd0, done}, 64'd1);
    check("t3_cnt", 64'(cnt), 64'd0);
    check("t3_sum", 64'(sum), 64'd0);
    check("t3_max", 64'(mx),  64'd0);
    cycle();
    check("t3_done_low", {63'd0, done}, 64'd0);
    repeat (2) cycle();
    check("t3_ready_never", 64'(ready_cnt), 64'd0);
    check("t3_one_pulse",   64'(done_cnt - d0), 64'd1);

    // Four samples with bubbles; valid stays high after the last one.
    hs_cnt = 0;
    do_start(16'd4);
    send(32'h0000_000F, 32'h0000_0001, 33'h0_0000_000F, 1'b0);
    cycle();
    send(32'h0000_0100, 32'h0000_0200, 33'h0_0000_0300, 1'b0);
    cycle();
    send(32'h0000_00FF, 32'h0000_00FF, 33'h0_0000_00FF, 1'b0);
    cycle();
    send(32'hFFFF_FFFF, 32'h0000_0001, 33'h0_FFFF_FFFF, 1'b1);
    a1 = 32'h0000_00FF; a2 = 32'h0000_00FF; apx = 33'h0_0000_00FF;
    check("t4_ready_drop", {63'd0, ready}, 64'd0);
    wait_done("t4");
    valid = 1'b0;
    check("t4_hs",     64'(hs_cnt), 64'd4);
    check("t4_cnt",    64'(cnt), 64'd3);
    check("t4_sum",    64'(sum), 64'h101);
    check("t4_max",    64'(mx),  64'hFF);
    check("t4_sat_sum", 64'(s_sum), 64'hFF);
    cycle();

    // Saturation of the 8-bit accumulator: 3 x 0x80.
    do_start(16'd3);
    for (int i = 0; i < 3; i++) send(32'h0000_0080, 32'h0000_0080, 33'h0_0000_0180, 1'b0);
    wait_done("t5");
    check("t5_sat_sum", 64'(s_sum), 64'hFF);
    check("t5_sat_max", 64'(s_mx),  64'h80);
    check("t5_sat_cnt", 64'(s_cnt), 64'd3);
    check("t5_sum",     64'(sum),   64'h180);
    cycle();

    // Reset after 2 of 5 samples discards the window.
    d0 = done_cnt;
    do_start(16'd5);
    send(32'h0000_00FF, 32'h0000_00FF, 33'h0_0000_00FF, 1'b0);
    send(32'h0000_00FF, 32'h0000_00FF, 33'h0_0000_00FF, 1'b0);
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t6_ready", {63'd0, ready}, 64'd0);
    check("t6_busy",  {63'd0, busy},  64'd0);
    check("t6_cnt",   64'(cnt), 64'd0);
    check("t6_sum",   64'(sum), 64'd0);
    check("t6_max",   64'(mx),  64'd0);
    repeat (6) cycle();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_idle",    {63'd0, busy}, 64'd0);
    do_start(16'd1);
    send(32'h0000_00FF, 32'h0000_0001, 33'h0_0000_00FF, 1'b0);
    wait_done("t6b");
    check("t6b_cnt", 64'(cnt), 64'd1);
    check("t6b_sum", 64'(sum), 64'd1);
    check("t6b_max", 64'(mx),  64'd1);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
